// File: rtl/reference_clock_divider_if.sv
// Configuration port of the reference clock divider: one valid/ready request
// carrying a requested period and high time.
interface reference_clock_divider_if #(
  parameter int DIV_WIDTH = 8
);
  logic                 cfgValid;
  logic                 cfgReady;
  logic [DIV_WIDTH-1:0] cfgDivisor;
  logic [DIV_WIDTH-1:0] cfgHighCycles;

  modport master (output cfgValid, output cfgDivisor, output cfgHighCycles, input cfgReady);
  modport slave  (input cfgValid, input cfgDivisor, input cfgHighCycles, output cfgReady);
endinterface

// File: rtl/reference_clock_divider.sv
// Glitch-free programmable clock divider with edge markers. New settings are
// held in a single pending slot and only take effect at a period boundary.
module reference_clock_divider #(
  parameter int DIV_WIDTH  = 8,
  parameter int INIT_DIV   = 4,
  parameter int INIT_HIGH  = 2,
  parameter int INIT_VALUE = 0
) (
  input  logic                     clockIn,
  input  logic                     resetN,
  reference_clock_divider_if.slave cfg,
  output logic                     clockOut,
  output logic                     risePulse,
  output logic                     fallPulse,
  output logic [DIV_WIDTH-1:0]     curDivisor,
  output logic                     cfgPending
);

  localparam logic [DIV_WIDTH-1:0] INIT_DIV_V  = DIV_WIDTH'(INIT_DIV);
  localparam logic [DIV_WIDTH-1:0] INIT_HIGH_V = DIV_WIDTH'(INIT_HIGH);
  localparam logic                 INIT_LEVEL  = ((INIT_VALUE % 2) != 0);
  // Starting at cnt==high puts a low start at the first low cycle of a period.
  localparam logic [DIV_WIDTH-1:0] INIT_CNT_V  = INIT_LEVEL ? {DIV_WIDTH{1'b0}} : INIT_HIGH_V;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_HELD = 1'b1
  } cfgState_t;

  function automatic logic [DIV_WIDTH-1:0] clampDiv(input logic [DIV_WIDTH-1:0] d);
    logic [DIV_WIDTH-1:0] r;
    if (d < DIV_WIDTH'(2)) begin
      r = DIV_WIDTH'(2);
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic logic [DIV_WIDTH-1:0] clampHigh(input logic [DIV_WIDTH-1:0] h,
                                                     input logic [DIV_WIDTH-1:0] d);
    logic [DIV_WIDTH-1:0] r;
    if (h == {DIV_WIDTH{1'b0}}) begin
      r = DIV_WIDTH'(1);
    end else begin
      r = h;
    end
    if (r >= d) begin
      r = d - DIV_WIDTH'(1);
    end else begin
      r = r;
    end
    return r;
  endfunction

  cfgState_t            state_r, nextState_s;
  logic                 ready_r, pending_r;
  logic [DIV_WIDTH-1:0] pendDiv_r, pendHigh_r;
  logic [DIV_WIDTH-1:0] div_r, high_r, cnt_r;
  logic                 clockOut_r, rise_r, fall_r;
  logic                 wrap_s, accept_s, apply_s, nextClock_s;
  logic [DIV_WIDTH-1:0] nextCnt_s, nextDiv_s, nextHigh_s, newDiv_s;

  // Handshake state: idle (slot free) or holding an accepted request.
  always_comb begin
    nextState_s = state_r;
    accept_s    = 1'b0;
    apply_s     = 1'b0;
    case (state_r)
      CFG_IDLE: begin
        accept_s = cfg.cfgValid;
        if (cfg.cfgValid) begin
          nextState_s = CFG_HELD;
        end else begin
          nextState_s = CFG_IDLE;
        end
      end
      CFG_HELD: begin
        apply_s = wrap_s;
        if (wrap_s) begin
          nextState_s = CFG_IDLE;
        end else begin
          nextState_s = CFG_HELD;
        end
      end
      default: begin
        nextState_s = CFG_IDLE;
      end
    endcase
  end

  // Period counter and the level for the next cycle, using new settings on apply.
  always_comb begin
    wrap_s   = (cnt_r == (div_r - DIV_WIDTH'(1)));
    newDiv_s = clampDiv(pendDiv_r);
    if (apply_s) begin
      nextDiv_s  = newDiv_s;
      nextHigh_s = clampHigh(pendHigh_r, newDiv_s);
    end else begin
      nextDiv_s  = div_r;
      nextHigh_s = high_r;
    end
    if (wrap_s) begin
      nextCnt_s = {DIV_WIDTH{1'b0}};
    end else begin
      nextCnt_s = cnt_r + DIV_WIDTH'(1);
    end
    nextClock_s = (nextCnt_s < nextHigh_s);
  end

  // Handshake registers and the single pending slot.
  always_ff @(posedge clockIn or negedge resetN) begin
    if (!resetN) begin
      state_r    <= CFG_IDLE;
      ready_r    <= 1'b1;
      pending_r  <= 1'b0;
      pendDiv_r  <= {DIV_WIDTH{1'b0}};
      pendHigh_r <= {DIV_WIDTH{1'b0}};
    end else begin
      state_r   <= nextState_s;
      ready_r   <= (nextState_s == CFG_IDLE);
      pending_r <= (nextState_s == CFG_HELD);
      if (accept_s) begin
        pendDiv_r  <= cfg.cfgDivisor;
        pendHigh_r <= cfg.cfgHighCycles;
      end
    end
  end

  // Divider datapath; pulses compare the new level with the level being replaced.
  always_ff @(posedge clockIn or negedge resetN) begin
    if (!resetN) begin
      div_r      <= INIT_DIV_V;
      high_r     <= INIT_HIGH_V;
      cnt_r      <= INIT_CNT_V;
      clockOut_r <= INIT_LEVEL;
      rise_r     <= 1'b0;
      fall_r     <= 1'b0;
    end else begin
      div_r      <= nextDiv_s;
      high_r     <= nextHigh_s;
      cnt_r      <= nextCnt_s;
      clockOut_r <= nextClock_s;
      rise_r     <= nextClock_s & ~clockOut_r;
      fall_r     <= ~nextClock_s & clockOut_r;
    end
  end

  assign cfg.cfgReady = ready_r;
  assign cfgPending   = pending_r;
  assign clockOut     = clockOut_r;
  assign risePulse    = rise_r;
  assign fallPulse    = fall_r;
  assign curDivisor   = div_r;

endmodule
